cr16_step_ctrl: RTL

- Clock-enable generator directly upstream of the cr16 test FSM; drives that FSM's I_ENABLE so each datapath/ALU test state can be advanced from the board.
- Two modes: single-step, one enable pulse per debounced pushbutton press; free-run, one enable pulse every RUN_DIVIDE clocks.
- A halt input from downstream freezes stepping.
- Exposes a step counter and mode for display on board LEDs / seven-segment.

---
 rtl/cr16_step_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cr16_step_ctrl.sv
// cr16_step_ctrl: clock-enable generator for the cr16 test FSM.
// Step mode issues one enable per debounced button press. Run mode issues one
// enable every RUN_DIVIDE clocks. A downstream halt freezes both modes, and a
// 16-bit count of issued enables is exposed for the board display.
module cr16_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIVIDE      = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_STEP_BTN,
  input  logic        I_RUN_SW,
  input  logic        I_HALT,
  output logic        O_ENABLE,
  output logic [15:0] O_STEP_COUNT,
  output logic [1:0]  O_MODE,
  output logic        O_BTN_STABLE
);

  typedef enum logic [1:0] {
    ST_STEP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  // Bit positions of the two debounced inputs in the packed vectors below.
  localparam int BTN = 0;
  localparam int SW  = 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIVIDE - 1);

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic             btn_prev_q;
  logic             btn_rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             enable_q, enable_d;
  logic [15:0]      step_count_q, step_count_d;

  // Two-flop synchronizers; the only logic that touches the raw inputs.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!I_NRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {I_RUN_SW, I_STEP_BTN};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatches, adopt the new level on the last one.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned
    // (which would infer a latch).
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and button edge-detect history.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      stable_q   <= '0;
      btn_prev_q <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset; a partial debounce must never survive reset.
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      stable_q   <= stable_d;
      btn_prev_q <= stable_q[BTN];
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // The edge is consumed every cycle whatever the state, so a press seen while
  // halted or running is dropped rather than queued.
  assign btn_rise = stable_q[BTN] & ~btn_prev_q;

  // Mode FSM, divider and pulse generation; halt beats switch beats pulse.
  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    enable_d     = 1'b0;
    step_count_d = step_count_q;
    case (state_q)
      ST_STEP: begin
        if (I_HALT) begin
          state_d = ST_HALTED;
        end else if (stable_q[SW]) begin
          state_d = ST_RUN;
        end else if (btn_rise) begin
          enable_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (I_HALT) begin
          state_d = ST_HALTED;
        end else if (!stable_q[SW]) begin
          state_d = ST_STEP;
        end else if (div_q == DIV_LAST) begin
          enable_d = 1'b1;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        if (!I_HALT) begin
          state_d = stable_q[SW] ? ST_RUN : ST_STEP;
        end
      end
      default: begin
        state_d = ST_STEP;
      end
    endcase
    if (enable_d) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  // FSM state, divider, enable pulse and step counter registers.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q      <= ST_STEP;
      div_q        <= '0;
      enable_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      enable_q     <= enable_d;
      step_count_q <= step_count_d;
    end
  end

  assign O_ENABLE     = enable_q;
  assign O_STEP_COUNT = step_count_q;
  assign O_MODE       = state_q;
  assign O_BTN_STABLE = stable_q[BTN];

endmodule
